// File: rtl/pe_array_stream.sv
// X_DIM x Y_DIM grid of signed MAC cells: cell (i,j) accumulates actn[i]*filt[j] over cfg_k
// input beats, then the results drain column by column through a valid/ready output stream.
module pe_array_stream #(
   parameter int unsigned X_DIM      = 4,
   parameter int unsigned Y_DIM      = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 4,
   parameter int unsigned K_W        = 8,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [K_W-1:0]                cfg_k,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [X_DIM*DATA_WIDTH-1:0]   actn_in,
   input  logic [Y_DIM*DATA_WIDTH-1:0]   filt_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [X_DIM*ACC_WIDTH-1:0]    out_data,
   output logic [$clog2(Y_DIM)-1:0]      out_col,
   output logic                          out_last
);

   localparam int unsigned COL_W = $clog2(Y_DIM);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(Y_DIM - 1);

   typedef enum logic [1:0] {StIdle, StCompute, StDrain, StFinish} state_e;

   state_e         state_q;
   logic [K_W-1:0] k_q;
   logic [K_W-1:0] step_q;
   logic [COL_W-1:0] col_q;

   logic signed [ACC_WIDTH-1:0] acc_q [X_DIM][Y_DIM];
   logic signed [ACC_WIDTH-1:0] acc_d [X_DIM][Y_DIM];

   logic start_fire;
   logic in_fire;

   // One MAC step with an extra guard bit to detect signed overflow of the add.
   function automatic logic signed [ACC_WIDTH-1:0] mac_step(
      input logic signed [ACC_WIDTH-1:0]  acc,
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] f
   );
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH:0]      sum;
      prod = a * f;
      sum  = $signed({acc[ACC_WIDTH-1], acc}) +
             $signed({{(ACC_WIDTH + 1 - 2 * DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod});
      if (SATURATE && (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])) begin
         mac_step = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
      end else begin
         mac_step = sum[ACC_WIDTH-1:0];
      end
   endfunction

   assign start_fire = (state_q == StIdle) && start;
   assign in_fire    = (state_q == StCompute) && in_valid;

   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StFinish);
      in_ready  = (state_q == StCompute);
      out_valid = (state_q == StDrain);
      out_last  = (state_q == StDrain) && (col_q == LAST_COL);
      out_col   = col_q;
      out_data  = '0;
      for (int unsigned i = 0; i < X_DIM; i++) begin
         out_data[i*ACC_WIDTH +: ACC_WIDTH] = acc_q[i][col_q];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         k_q     <= '0;
         step_q  <= '0;
         col_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  k_q     <= cfg_k;
                  step_q  <= '0;
                  col_q   <= '0;
                  // A zero-step run still drains its cleared accumulators.
                  state_q <= (cfg_k == '0) ? StDrain : StCompute;
               end
            end
            StCompute: begin
               if (in_valid) begin
                  step_q <= step_q + K_W'(1);
                  if (step_q == k_q - K_W'(1)) begin
                     col_q   <= '0;
                     state_q <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (out_ready) begin
                  if (col_q == LAST_COL) begin
                     col_q   <= '0;
                     state_q <= StFinish;
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
               end
            end
            StFinish: state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      acc_d = acc_q;
      for (int unsigned i = 0; i < X_DIM; i++) begin
         for (int unsigned j = 0; j < Y_DIM; j++) begin
            if (start_fire) begin
               acc_d[i][j] = '0;
            end else if (in_fire) begin
               acc_d[i][j] = mac_step(acc_q[i][j],
                                      actn_in[i*DATA_WIDTH +: DATA_WIDTH],
                                      filt_in[j*DATA_WIDTH +: DATA_WIDTH]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < X_DIM; i++) begin
            for (int unsigned j = 0; j < Y_DIM; j++) begin
               acc_q[i][j] <= '0;
            end
         end
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: tb/tb_pe_array_stream.sv
// Randomised bench for pe_array_stream: a saturating and a wrapping instance share stimulus and
// are compared against an arithmetic reference of the outer-product accumulation.
module tb_pe_array_stream;

   localparam int X  = 4;
   localparam int Y  = 4;
   localparam int DW = 8;
   localparam int AW = 2 * DW + 4;
   localparam int KW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [KW-1:0]   cfg_k = '0;
   logic            start = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [X*DW-1:0] actn_in = '0;
   logic [Y*DW-1:0] filt_in = '0;

   logic            busy_s, done_s, in_ready_s, out_valid_s, out_last_s;
   logic [X*AW-1:0] out_data_s;
   logic [1:0]      out_col_s;
   logic            busy_w, done_w, in_ready_w, out_valid_w, out_last_w;
   logic [X*AW-1:0] out_data_w;
   logic [1:0]      out_col_w;

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [DW-1:0] a_v [X];
   logic signed [DW-1:0] f_v [Y];
   longint acc_m [2][X][Y];  // [0] saturating, [1] wrapping
   longint res_s [X][Y];
   longint res_w [X][Y];

   always #5 clk = ~clk;

   pe_array_stream #(.X_DIM(X), .Y_DIM(Y), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_W(KW),
                     .SATURATE(1'b1)) u_dut_sat (
      .clk(clk), .rst(rst), .cfg_k(cfg_k), .start(start), .busy(busy_s), .done(done_s),
      .in_valid(in_valid), .in_ready(in_ready_s), .actn_in(actn_in), .filt_in(filt_in),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .out_col(out_col_s), .out_last(out_last_s)
   );

   pe_array_stream #(.X_DIM(X), .Y_DIM(Y), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_W(KW),
                     .SATURATE(1'b0)) u_dut_wrap (
      .clk(clk), .rst(rst), .cfg_k(cfg_k), .start(start), .busy(busy_w), .done(done_w),
      .in_valid(in_valid), .in_ready(in_ready_w), .actn_in(actn_in), .filt_in(filt_in),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
      .out_col(out_col_w), .out_last(out_last_w)
   );

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint mac_ref(input longint acc, input longint p, input bit sat);
      longint s;
      longint lim;
      s   = acc + p;
      lim = longint'(1) << (AW - 1);
      if (sat) begin
         if (s > lim - 1) s = lim - 1;
         else if (s < -lim) s = -lim;
      end else begin
         s = s & ((lim << 1) - 1);
         if (s >= lim) s = s - (lim << 1);
      end
      return s;
   endfunction

   // mode: 0 random, 1 all -128, 2 all ones, 3 small hand-worked case, 4 -128 x 127
   task automatic gen_beat(input int mode, input int b);
      for (int i = 0; i < X; i++) begin
         case (mode)
            0: a_v[i] = DW'($urandom);
            1: a_v[i] = -8'sd128;
            2: a_v[i] = 8'sd1;
            3: a_v[i] = (i == 0) ? ((b == 0) ? 8'sd1 : 8'sd3) :
                        (i == 1) ? ((b == 0) ? 8'sd2 : 8'sd4) : 8'sd0;
            default: a_v[i] = -8'sd128;
         endcase
         actn_in[i*DW +: DW] = a_v[i];
      end
      for (int j = 0; j < Y; j++) begin
         case (mode)
            0: f_v[j] = DW'($urandom);
            1: f_v[j] = -8'sd128;
            2: f_v[j] = 8'sd1;
            3: f_v[j] = (j == 0) ? ((b == 0) ? 8'sd5 : 8'sd7) :
                        (j == 1) ? ((b == 0) ? 8'sd6 : 8'sd8) : 8'sd0;
            default: f_v[j] = 8'sd127;
         endcase
         filt_in[j*DW +: DW] = f_v[j];
      end
   endtask

   task automatic run(input int k, input int mode, input bit stall, input bit spam,
                      input bit abort);
      int     b;
      int     c;
      int     cyc;
      int     held;
      longint g;
      @(negedge clk);
      check_eq("idle_busy", busy_s, 0);
      cfg_k = KW'(k);
      start = 1'b1;
      for (int i = 0; i < X; i++)
         for (int j = 0; j < Y; j++) begin
            acc_m[0][i][j] = 0;
            acc_m[1][i][j] = 0;
         end
      b   = 0;
      cyc = 0;
      while (b < k && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = spam;
         if (spam) cfg_k = 8'd7;
         check_eq("busy_compute", busy_s, 1);
         check_eq("in_ready_compute", in_ready_s, 1);
         gen_beat(mode, b);
         if (stall) in_valid = (cyc % 2 == 1);
         else if (mode == 0) in_valid = 1'($urandom);
         else in_valid = 1'b1;
         if (in_valid) begin
            for (int i = 0; i < X; i++)
               for (int j = 0; j < Y; j++) begin
                  acc_m[0][i][j] = mac_ref(acc_m[0][i][j], longint'(a_v[i]) * longint'(f_v[j]), 1);
                  acc_m[1][i][j] = mac_ref(acc_m[1][i][j], longint'(a_v[i]) * longint'(f_v[j]), 0);
               end
            b++;
         end
      end
      check_eq("compute_timeout", b, k);
      c    = 0;
      cyc  = 0;
      held = 0;
      while (c < Y && cyc < 500) begin
         @(negedge clk);
         cyc++;
         start    = 1'b0;
         gen_beat(0, 0);
         in_valid = 1'($urandom);
         check_eq("out_valid", out_valid_s, 1);
         check_eq("out_valid_wrap", out_valid_w, 1);
         check_eq("in_ready_drain", in_ready_s, 0);
         check_eq("done_early", done_s, 0);
         check_eq("out_col", out_col_s, c);
         check_eq("out_col_wrap", out_col_w, c);
         check_eq("out_last", out_last_s, (c == Y - 1));
         for (int i = 0; i < X; i++) begin
            g = $signed(out_data_s[i*AW +: AW]);
            check_eq("data_sat", g, acc_m[0][i][c]);
            res_s[i][c] = g;
            g = $signed(out_data_w[i*AW +: AW]);
            check_eq("data_wrap", g, acc_m[1][i][c]);
            res_w[i][c] = g;
         end
         if (stall && c == 0 && held < 5) begin
            out_ready = 1'b0;
            held++;
         end else if (stall) begin
            out_ready = 1'($urandom);
         end else begin
            out_ready = 1'b1;
         end
         if (out_ready) c++;
         if (abort && c == 1) break;
      end
      if (abort) begin
         @(posedge clk);
         #2;
         rst = 1'b0;
         #1;
         check_eq("rst_out_valid", out_valid_s, 0);
         check_eq("rst_busy", busy_s, 0);
         check_eq("rst_out_col", out_col_s, 0);
         check_eq("rst_out_data_zero", (out_data_s == '0), 1);
         out_ready = 1'b0;
         repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_done", done_s, 0);
         end
         rst = 1'b1;
         return;
      end
      check_eq("drain_timeout", c, Y);
      @(negedge clk);
      out_ready = 1'($urandom);
      check_eq("done_pulse", done_s, 1);
      check_eq("done_pulse_wrap", done_w, 1);
      check_eq("finish_out_valid", out_valid_s, 0);
      check_eq("finish_busy", busy_s, 1);
      @(negedge clk);
      check_eq("done_single", done_s, 0);
      check_eq("idle_after_done", busy_s, 0);
   endtask

   initial begin
      #12;
      check_eq("reset_busy", busy_s, 0);
      check_eq("reset_done", done_s, 0);
      check_eq("reset_in_ready", in_ready_s, 0);
      check_eq("reset_out_valid", out_valid_s, 0);
      check_eq("reset_out_last", out_last_s, 0);
      check_eq("reset_out_col", out_col_s, 0);
      check_eq("reset_out_data_zero", (out_data_s == '0), 1);
      @(negedge clk);
      rst = 1'b1;

      run(2, 3, 1'b0, 1'b0, 1'b0);
      check_eq("basic_c0r0", res_s[0][0], 26);
      check_eq("basic_c0r1", res_s[1][0], 38);
      check_eq("basic_c1r0", res_s[0][1], 30);
      check_eq("basic_c1r1", res_s[1][1], 44);

      run(2, 3, 1'b1, 1'b0, 1'b0);
      check_eq("bp_c0r0", res_s[0][0], 26);
      check_eq("bp_c1r1", res_s[1][1], 44);

      repeat (4) run($urandom_range(1, 12), 0, 1'($urandom), 1'b0, 1'b0);

      run(64, 1, 1'b0, 1'b0, 1'b0);
      check_eq("sat_pos", res_s[0][0], 524287);
      check_eq("wrap_pos", res_w[0][0], 0);

      run(40, 4, 1'b0, 1'b0, 1'b0);
      check_eq("sat_neg", res_s[2][3], -524288);
      check_eq("wrap_neg", res_w[2][3], 398336);

      run(0, 0, 1'b0, 1'b0, 1'b0);
      check_eq("k0_zero", res_s[3][2], 0);

      run(3, 0, 1'b0, 1'b0, 1'b1);
      run(1, 2, 1'b0, 1'b0, 1'b0);
      check_eq("after_rst_ones", res_s[3][3], 1);

      run(2, 0, 1'b1, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
